// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and helpers shared by the sequential ALU
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic is_multicycle(input logic [3:0] op, input int amt);
      return op == OP_MUL || ((op == OP_SHL || op == OP_SHR) && amt != 0);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: issue/writeback handshake bundle; OverflowFlag exists only with ALU_SEQ_OVF_FLAG_EN
interface alu_seq_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       op_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             CarryOut;
   logic             ZeroFlag;
   logic             IllegalOp;
`ifdef ALU_SEQ_OVF_FLAG_EN
   logic             OverflowFlag;
`endif

   modport master (
      output in_valid, A, B, op_sel, out_ready,
      input  in_ready, out_valid, Result, CarryOut, ZeroFlag, IllegalOp
`ifdef ALU_SEQ_OVF_FLAG_EN
      , OverflowFlag
`endif
   );

   modport slave (
      input  in_valid, A, B, op_sel, out_ready,
      output in_ready, out_valid, Result, CarryOut, ZeroFlag, IllegalOp
`ifdef ALU_SEQ_OVF_FLAG_EN
      , OverflowFlag
`endif
   );

endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: one-step-per-cycle shift and shift-add multiply datapath
module alu_seq_iter
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] amt,
   output logic               done,
   output logic [WIDTH-1:0]   res,
   output logic               carry
);

   localparam logic [SHAMT_W-1:0] W_AMT = SHAMT_W'(WIDTH);

   logic                 busy, mul, shl;
   logic [SHAMT_W-1:0]   cnt, tgt;
   logic [WIDTH-1:0]     sh, mp, sh_nxt;
   logic [2*WIDTH-1:0]   acc, mc, acc_nxt;
   logic                 c_nxt;

   // Values after this cycle's step; the top captures them on the final step
   always_comb begin
      sh_nxt  = shl ? sh << 1 : sh >> 1;
      c_nxt   = shl ? sh[WIDTH-1] : sh[0];
      acc_nxt = mp[0] ? acc + mc : acc;
   end

   assign done  = busy && (cnt + 1'b1 == tgt);
   assign res   = mul ? acc_nxt[WIDTH-1:0] : sh_nxt;
   assign carry = mul ? |acc_nxt[2*WIDTH-1:WIDTH] : c_nxt;

   // Load operands on start, then advance one shift or add step per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         mul  <= 1'b0;
         shl  <= 1'b0;
         cnt  <= '0;
         tgt  <= '0;
         sh   <= '0;
         mp   <= '0;
         acc  <= '0;
         mc   <= '0;
      end else if (start) begin
         busy <= 1'b1;
         mul  <= op == OP_MUL;
         shl  <= op == OP_SHL;
         cnt  <= '0;
         tgt  <= op == OP_MUL ? W_AMT : amt;
         sh   <= a;
         mp   <= b;
         acc  <= '0;
         mc   <= {{WIDTH{1'b0}}, a};
      end else if (busy) begin
         busy <= !done;
         cnt  <= cnt + 1'b1;
         sh   <= sh_nxt;
         acc  <= acc_nxt;
         mc   <= mc << 1;
         mp   <= mp >> 1;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with iterative shift/multiply; optional ALU_SEQ_OVF_FLAG_EN adds OverflowFlag
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
   input logic      clk,
   input logic      rst_n,
   alu_seq_if.slave ifc
);

   localparam logic [SHAMT_W-1:0] W_AMT = SHAMT_W'(WIDTH);

   state_t               state, state_nxt;
   logic                 accept, multi, it_done, it_carry, sc_c, sc_ill;
   logic [SHAMT_W-1:0]   amt;
   logic [WIDTH-1:0]     it_res, sc_res;

   assign ifc.in_ready  = state == IDLE || (state == DONE && ifc.out_ready);
   assign ifc.out_valid = state == DONE;
   assign accept        = ifc.in_valid && ifc.in_ready;
   assign amt           = ifc.B[SHAMT_W-1:0] > W_AMT ? W_AMT : ifc.B[SHAMT_W-1:0];
   assign multi         = is_multicycle(ifc.op_sel, int'(amt));

   alu_seq_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept && multi),
      .op    (ifc.op_sel),
      .a     (ifc.A),
      .b     (ifc.B),
      .amt   (amt),
      .done  (it_done),
      .res   (it_res),
      .carry (it_carry)
   );

   // Single-cycle results; shifts by zero pass A through unchanged
   always_comb begin
      sc_res = '0;
      sc_c   = 1'b0;
      sc_ill = 1'b0;
      case (ifc.op_sel)
         OP_ADD:                 {sc_c, sc_res} = {1'b0, ifc.A} + {1'b0, ifc.B};
         OP_SUB: begin
            sc_res = ifc.A - ifc.B;
            sc_c   = ifc.A < ifc.B;
         end
         OP_AND:                 sc_res = ifc.A & ifc.B;
         OP_OR:                  sc_res = ifc.A | ifc.B;
         OP_XOR:                 sc_res = ifc.A ^ ifc.B;
         OP_NOT:                 sc_res = ~ifc.A;
         OP_SHL, OP_SHR, OP_MUL: sc_res = ifc.A;
         default:                sc_ill = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state; a DONE result consumed alongside a new accept chains straight on
   always_comb begin
      state_nxt = state;
      state_nxt = state == BUSY                   ? (it_done ? DONE : BUSY) :
                  accept                          ? (multi ? BUSY : DONE) :
                  state == DONE && !ifc.out_ready ? DONE : IDLE;
   end

   // Result and flags change only when a new result completes, so they hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifc.Result    <= '0;
         ifc.CarryOut  <= 1'b0;
         ifc.ZeroFlag  <= 1'b0;
         ifc.IllegalOp <= 1'b0;
      end else if (accept && !multi) begin
         ifc.Result    <= sc_res;
         ifc.CarryOut  <= sc_c;
         ifc.ZeroFlag  <= sc_res == '0;
         ifc.IllegalOp <= sc_ill;
      end else if (it_done) begin
         ifc.Result    <= it_res;
         ifc.CarryOut  <= it_carry;
         ifc.ZeroFlag  <= it_res == '0;
         ifc.IllegalOp <= 1'b0;
      end
   end

`ifdef ALU_SEQ_OVF_FLAG_EN
   logic mul_r, sc_ovf;

   assign sc_ovf = ifc.op_sel == OP_ADD ? (ifc.A[WIDTH-1] == ifc.B[WIDTH-1] && sc_res[WIDTH-1] != ifc.A[WIDTH-1]) :
                   ifc.op_sel == OP_SUB ? (ifc.A[WIDTH-1] != ifc.B[WIDTH-1] && sc_res[WIDTH-1] != ifc.A[WIDTH-1]) :
                   1'b0;

   // Signed overflow for ADD/SUB; for MUL it mirrors the high-product carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_r            <= 1'b0;
         ifc.OverflowFlag <= 1'b0;
      end else if (accept) begin
         mul_r <= ifc.op_sel == OP_MUL;
         if (!multi) ifc.OverflowFlag <= sc_ovf;
      end else if (it_done) begin
         ifc.OverflowFlag <= mul_r && it_carry;
      end
   end
`endif

endmodule
